dcache_bypass_arbiter: RTL and testbench

- Shares one single-outstanding memory request channel among the cache-bypass requesters: PTW, load, store, and the AMO sequencer.
- Sits between the no-dcache bypass controller's request ports and the AXI adapter.
- Grants requesters round-robin, holds one transaction in flight, and routes the response back to its owner.
- Provides a flush handshake that drains the channel.

---
 rtl/dcache_bypass_arbiter_pkg.sv | 36 +++
 rtl/dcache_rr_select.sv | 46 ++++
 rtl/dcache_bypass_arbiter.sv | 140 ++++++++++++++
 tb/tb_dcache_bypass_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_bypass_arbiter_pkg.sv
// ============================================================================
// Module   : dcache_bypass_arbiter_pkg
// Brief    : Shared types for the cache-bypass request arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dcache_bypass_arbiter_pkg;

    typedef enum logic [1:0] {
        Idle     = 2'd0,
        Send     = 2'd1,
        WaitResp = 2'd2
    } arb_state_e;

    localparam int unsigned c_PORT_PTW   = 0;
    localparam int unsigned c_PORT_LOAD  = 1;
    localparam int unsigned c_PORT_STORE = 2;
    localparam int unsigned c_PORT_AMO   = 3;

    // Storage is sized for the widest supported bus; narrower configurations use the low bits.
    localparam int unsigned c_MAX_ADDR_W = 64;
    localparam int unsigned c_MAX_DATA_W = 64;
    localparam int unsigned c_MAX_BE_W   = c_MAX_DATA_W / 8;

    typedef struct packed {
        logic [c_MAX_ADDR_W-1:0] addr;
        logic                    we;
        logic [c_MAX_DATA_W-1:0] wdata;
        logic [c_MAX_BE_W-1:0]   be;
        logic [1:0]              size;
    } bypass_req_t;

endpackage

`default_nettype wire

// File: rtl/dcache_rr_select.sv
// ============================================================================
// Module   : dcache_rr_select
// Brief    : Combinational round-robin pick: first set request at or above ptr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_rr_select #(
    parameter int unsigned NR_PORTS = 3,
    parameter int unsigned IDX_W    = 2
) (
    input  logic [NR_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]    ptr_i,
    output logic [NR_PORTS-1:0] gnt_o,
    output logic [IDX_W-1:0]    idx_o,
    output logic                valid_o
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_cand;

    // Walk offsets from farthest to nearest so the nearest set request wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        w_sum   = '0;
        w_cand  = '0;
        for (int i = NR_PORTS - 1; i >= 0; i--) begin
            w_sum = {1'b0, ptr_i} + (IDX_W+1)'(i);
            if (w_sum >= (IDX_W+1)'(NR_PORTS)) begin
                w_sum = w_sum - (IDX_W+1)'(NR_PORTS);
            end
            w_cand = w_sum[IDX_W-1:0];
            if (req_i[w_cand]) begin
                gnt_o         = '0;
                gnt_o[w_cand] = 1'b1;
                idx_o         = w_cand;
                valid_o       = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dcache_bypass_arbiter.sv
// ============================================================================
// Module   : dcache_bypass_arbiter
// Brief    : Round-robin arbiter sharing one single-outstanding bypass channel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_bypass_arbiter
    import dcache_bypass_arbiter_pkg::*;
#(
    parameter int unsigned NR_PORTS   = 3,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           flush_i,
    output logic                           flush_ack_o,
    output logic                           busy_o,
    input  logic [NR_PORTS-1:0]            req_i,
    output logic [NR_PORTS-1:0]            gnt_o,
    input  logic [NR_PORTS*ADDR_WIDTH-1:0] addr_i,
    input  logic [NR_PORTS-1:0]            we_i,
    input  logic [NR_PORTS*DATA_WIDTH-1:0] wdata_i,
    input  logic [NR_PORTS*DATA_WIDTH/8-1:0] be_i,
    input  logic [NR_PORTS*2-1:0]          size_i,
    output logic [NR_PORTS-1:0]            rvalid_o,
    output logic [DATA_WIDTH-1:0]          rdata_o,
    output logic                           mem_req_o,
    input  logic                           mem_gnt_i,
    output logic [ADDR_WIDTH-1:0]          mem_addr_o,
    output logic                           mem_we_o,
    output logic [DATA_WIDTH-1:0]          mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0]        mem_be_o,
    output logic [1:0]                     mem_size_o,
    input  logic                           mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]          mem_rdata_i
);

    localparam int unsigned c_IDX_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
    localparam int unsigned c_BE_W  = DATA_WIDTH / 8;

    arb_state_e       r_state, w_state_d;
    logic [c_IDX_W-1:0] r_rr, w_rr_d;
    logic [c_IDX_W-1:0] r_owner;
    bypass_req_t      r_req;
    bypass_req_t      w_port_req [NR_PORTS];

    logic [NR_PORTS-1:0] w_sel_gnt;
    logic [c_IDX_W-1:0]  w_sel_idx;
    logic                w_sel_valid;
    logic                w_latch;

    for (genvar p = 0; p < NR_PORTS; p++) begin : g_port
        assign w_port_req[p].addr  = c_MAX_ADDR_W'(addr_i[p*ADDR_WIDTH +: ADDR_WIDTH]);
        assign w_port_req[p].we    = we_i[p];
        assign w_port_req[p].wdata = c_MAX_DATA_W'(wdata_i[p*DATA_WIDTH +: DATA_WIDTH]);
        assign w_port_req[p].be    = c_MAX_BE_W'(be_i[p*c_BE_W +: c_BE_W]);
        assign w_port_req[p].size  = size_i[p*2 +: 2];
    end

    dcache_rr_select #(
        .NR_PORTS (NR_PORTS),
        .IDX_W    (c_IDX_W)
    ) u_rr_select (
        .req_i   (req_i),
        .ptr_i   (r_rr),
        .gnt_o   (w_sel_gnt),
        .idx_o   (w_sel_idx),
        .valid_o (w_sel_valid)
    );

    always_comb begin
        w_state_d   = r_state;
        w_rr_d      = r_rr;
        w_latch     = 1'b0;
        gnt_o       = '0;
        flush_ack_o = 1'b0;
        rvalid_o    = '0;
        rdata_o     = '0;
        case (r_state)
            Idle: begin
                if (flush_i) begin
                    flush_ack_o = 1'b1;
                end else if (w_sel_valid) begin
                    gnt_o     = w_sel_gnt;
                    w_latch   = 1'b1;
                    w_state_d = Send;
                end
            end
            Send: begin
                if (mem_gnt_i) begin
                    w_state_d = WaitResp;
                end
            end
            WaitResp: begin
                if (mem_rvalid_i) begin
                    rvalid_o[r_owner] = 1'b1;
                    rdata_o           = mem_rdata_i;
                    // Next search starts just past the port that was served.
                    w_rr_d            = (r_owner == c_IDX_W'(NR_PORTS - 1)) ? '0 : r_owner + 1'b1;
                    w_state_d         = Idle;
                end
            end
            default: w_state_d = Idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= Idle;
            r_rr    <= '0;
            r_owner <= '0;
            r_req   <= '0;
        end else begin
            r_state <= w_state_d;
            r_rr    <= w_rr_d;
            if (w_latch) begin
                r_req   <= w_port_req[w_sel_idx];
                r_owner <= w_sel_idx;
            end
        end
    end

    assign busy_o      = (r_state != Idle);
    assign mem_req_o   = (r_state == Send);
    assign mem_addr_o  = r_req.addr[ADDR_WIDTH-1:0];
    assign mem_we_o    = r_req.we;
    assign mem_wdata_o = r_req.wdata[DATA_WIDTH-1:0];
    assign mem_be_o    = r_req.be[c_BE_W-1:0];
    assign mem_size_o  = r_req.size;

    a_gnt_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));
    a_rvalid_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(rvalid_o));
    a_mem_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (mem_req_o && !mem_gnt_i) |=> $stable({mem_addr_o, mem_we_o, mem_wdata_o, mem_be_o, mem_size_o}));

endmodule

`default_nettype wire

// File: tb/tb_dcache_bypass_arbiter.sv
// ============================================================================
// Module   : tb_dcache_bypass_arbiter
// Brief    : Self-checking bench: directed table, corner sequences, random traffic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcache_bypass_arbiter;
    import dcache_bypass_arbiter_pkg::*;

    localparam int NP = 3;
    localparam int AW = 64;
    localparam int DW = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush_i, flush_ack_o, busy_o;
    logic [NP-1:0]     req_i, gnt_o, we_i, rvalid_o;
    logic [NP*AW-1:0]  addr_i;
    logic [NP*DW-1:0]  wdata_i;
    logic [NP*DW/8-1:0] be_i;
    logic [NP*2-1:0]   size_i;
    logic [DW-1:0]     rdata_o, mem_wdata_o, mem_rdata_i;
    logic              mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i;
    logic [AW-1:0]     mem_addr_o;
    logic [DW/8-1:0]   mem_be_o;
    logic [1:0]        mem_size_o;

    logic [AW-1:0]     p_addr  [NP];
    logic              p_we    [NP];
    logic [DW-1:0]     p_wdata [NP];
    logic [7:0]        p_be    [NP];
    logic [1:0]        p_size  [NP];

    int checks = 0;
    int errors = 0;
    int rr_m   = 0;

    always #5 clk = ~clk;

    always_comb begin
        addr_i = '0; we_i = '0; wdata_i = '0; be_i = '0; size_i = '0;
        for (int p = 0; p < NP; p++) begin
            addr_i[p*AW +: AW]   = p_addr[p];
            we_i[p]              = p_we[p];
            wdata_i[p*DW +: DW]  = p_wdata[p];
            be_i[p*8 +: 8]       = p_be[p];
            size_i[p*2 +: 2]     = p_size[p];
        end
    end

    dcache_bypass_arbiter #(.NR_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_i), .flush_ack_o(flush_ack_o),
        .busy_o(busy_o), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i),
        .wdata_i(wdata_i), .be_i(be_i), .size_i(size_i), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
        .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o),
        .mem_be_o(mem_be_o), .mem_size_o(mem_size_o), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arbitration: first requester at or after the pointer, modulo NP.
    function automatic logic [NP-1:0] model_pick(input logic [NP-1:0] req);
        for (int off = 0; off < NP; off++) begin
            if (req[(rr_m + off) % NP]) return NP'(1 << ((rr_m + off) % NP));
        end
        return '0;
    endfunction

    task automatic randomize_ports();
        for (int p = 0; p < NP; p++) begin
            p_addr[p]  = {$urandom, $urandom};
            p_we[p]    = 1'($urandom_range(0, 1));
            p_wdata[p] = {$urandom, $urandom};
            p_be[p]    = 8'($urandom);
            p_size[p]  = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_gnt"}, 64'(gnt_o), 64'd0);
        chk({tag, "_rvalid"}, 64'(rvalid_o), 64'd0);
        chk({tag, "_rdata"}, rdata_o, 64'd0);
        chk({tag, "_mem_req"}, 64'(mem_req_o), 64'd0);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_flush_ack"}, 64'(flush_ack_o), 64'd0);
    endtask

    // One full transaction from the grant cycle to the response cycle.
    task automatic run_txn(input logic [NP-1:0] req, input int gnt_dly, input int rsp_dly,
                           input logic [NP-1:0] exp_gnt, input bit fixed, input bit flush_wait);
        int w;
        logic [63:0] e_addr, e_wdata, rd;
        logic        e_we;
        logic [7:0]  e_be;
        logic [1:0]  e_size;
        w = -1;
        if (!fixed) randomize_ports();
        @(negedge clk);
        req_i = req; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; flush_i = 1'b0;
        #1;
        chk("grant", 64'(gnt_o), 64'(exp_gnt));
        chk("busy_idle", 64'(busy_o), 64'd0);
        chk("mem_req_idle", 64'(mem_req_o), 64'd0);
        for (int p = 0; p < NP; p++) if (exp_gnt[p]) w = p;
        if (w < 0) return;
        e_addr = p_addr[w]; e_we = p_we[w]; e_wdata = p_wdata[w]; e_be = p_be[w]; e_size = p_size[w];
        for (int k = 0; k <= gnt_dly; k++) begin
            @(negedge clk);
            req_i = flush_wait ? req : NP'($urandom);
            randomize_ports();
            mem_gnt_i    = (k == gnt_dly);
            mem_rvalid_i = 1'($urandom_range(0, 1));
            mem_rdata_i  = {$urandom, $urandom};
            #1;
            chk("send_mem_req", 64'(mem_req_o), 64'd1);
            chk("send_addr", mem_addr_o, e_addr);
            chk("send_we", 64'(mem_we_o), 64'(e_we));
            chk("send_wdata", mem_wdata_o, e_wdata);
            chk("send_be", 64'(mem_be_o), 64'(e_be));
            chk("send_size", 64'(mem_size_o), 64'(e_size));
            chk("send_no_gnt", 64'(gnt_o), 64'd0);
            chk("send_no_rvalid", 64'(rvalid_o), 64'd0);
            chk("send_rdata_zero", rdata_o, 64'd0);
            chk("send_busy", 64'(busy_o), 64'd1);
        end
        for (int k = 0; k <= rsp_dly; k++) begin
            @(negedge clk);
            req_i = flush_wait ? req : NP'($urandom);
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = (k == rsp_dly);
            rd           = fixed ? 64'hDEAD_BEEF_0000_0001 : {$urandom, $urandom};
            mem_rdata_i  = rd;
            flush_i      = flush_wait;
            #1;
            chk("wait_mem_req", 64'(mem_req_o), 64'd0);
            chk("wait_no_gnt", 64'(gnt_o), 64'd0);
            chk("wait_flush_ack", 64'(flush_ack_o), 64'd0);
            chk("wait_busy", 64'(busy_o), 64'd1);
            chk("rvalid", 64'(rvalid_o), (k == rsp_dly) ? 64'(exp_gnt) : 64'd0);
            chk("rdata", rdata_o, (k == rsp_dly) ? rd : 64'd0);
        end
        rr_m = (w + 1) % NP;
        if (flush_wait) begin
            @(negedge clk);
            mem_rvalid_i = 1'b0;
            #1;
            chk("flush_ack_pulse", 64'(flush_ack_o), 64'd1);
            chk("flush_no_gnt", 64'(gnt_o), 64'd0);
            chk("flush_idle", 64'(busy_o), 64'd0);
            @(negedge clk);
            flush_i = 1'b0; req_i = '0;
            #1;
            chk("flush_ack_drop", 64'(flush_ack_o), 64'd0);
        end
    endtask

    typedef struct {
        logic [NP-1:0] req;
        int            gnt_dly;
        int            rsp_dly;
        logic [NP-1:0] exp_gnt;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic [NP-1:0] r, e;
        // Grant sequence assumes the pointer sits at 2 after the first directed read.
        tbl[0]  = '{3'b111, 0, 0, 3'b100};
        tbl[1]  = '{3'b111, 0, 0, 3'b001};
        tbl[2]  = '{3'b111, 0, 0, 3'b010};
        tbl[3]  = '{3'b111, 0, 0, 3'b100};
        tbl[4]  = '{3'b111, 1, 0, 3'b001};
        tbl[5]  = '{3'b111, 0, 1, 3'b010};
        tbl[6]  = '{3'b000, 0, 0, 3'b000};
        tbl[7]  = '{3'b001, 0, 0, 3'b001};
        tbl[8]  = '{3'b001, 0, 0, 3'b001};
        tbl[9]  = '{3'b101, 0, 0, 3'b100};
        tbl[10] = '{3'b110, 5, 0, 3'b010};
        tbl[11] = '{3'b011, 0, 3, 3'b001};
        tbl[12] = '{3'b100, 2, 2, 3'b100};

        rst_n = 1'b0; flush_i = 1'b0; req_i = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        randomize_ports();
        repeat (2) @(negedge clk);
        #1;
        chk_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed single read on the load port.
        p_addr[c_PORT_LOAD] = 64'h8000_0010; p_size[c_PORT_LOAD] = 2'd3; p_we[c_PORT_LOAD] = 1'b0;
        run_txn(3'b010, 0, 0, 3'b010, 1'b1, 1'b0);

        for (int i = 0; i < 13; i++) begin
            run_txn(tbl[i].req, tbl[i].gnt_dly, tbl[i].rsp_dly, tbl[i].exp_gnt, 1'b0, 1'b0);
        end

        // Directed write on the store port (pointer now 0).
        randomize_ports();
        p_we[c_PORT_STORE] = 1'b1; p_be[c_PORT_STORE] = 8'h0F; p_wdata[c_PORT_STORE] = 64'h1122_3344;
        run_txn(3'b100, 0, 0, 3'b100, 1'b1, 1'b0);

        // Flush raised while waiting for the response, two requesters pending.
        run_txn(3'b011, 0, 1, 3'b001, 1'b0, 1'b1);

        // Reset while waiting for a response; the late response must be dropped.
        @(negedge clk);
        req_i = 3'b110; flush_i = 1'b0;
        #1;
        chk("rst_seq_grant", 64'(gnt_o), 64'b010);
        @(negedge clk);
        req_i = '0; mem_gnt_i = 1'b1;
        @(negedge clk);
        mem_gnt_i = 1'b0;
        #1;
        chk("rst_seq_waiting", 64'(busy_o), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("midreset");
        rr_m = 0;
        @(negedge clk);
        rst_n = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 64'hCAFE_F00D_1234_5678;
        #1;
        chk("stale_rvalid", 64'(rvalid_o), 64'd0);
        chk("stale_rdata", rdata_o, 64'd0);
        chk("stale_busy", 64'(busy_o), 64'd0);
        run_txn(3'b111, 0, 0, 64'(1 << c_PORT_PTW), 1'b0, 1'b0);
        run_txn(3'b111, 0, 0, 3'b010, 1'b0, 1'b0);
        run_txn(3'b111, 0, 0, 3'b100, 1'b0, 1'b0);

        // Random traffic against the reference arbitration model.
        for (int i = 0; i < 80; i++) begin
            r = NP'($urandom_range(0, (1 << NP) - 1));
            e = model_pick(r);
            run_txn(r, $urandom_range(0, 3), $urandom_range(0, 3), e, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
